// File: rtl/obi_apb_bridge_if.sv
// rtl/obi_apb_bridge_if.sv - OBI request/response and APB bus bundle for the bridge
interface obi_apb_bridge_if #(
  parameter int OBI_AW  = 32,
  parameter int OBI_DW  = 32,
  parameter int OBI_IDW = 1
);
  // OBI request channel (initiator -> bridge)
  logic                  obi_req;
  logic [OBI_AW-1:0]     obi_addr;
  logic                  obi_we;
  logic [OBI_DW/8-1:0]   obi_be;
  logic [OBI_DW-1:0]     obi_wdata;
  logic [OBI_IDW-1:0]    obi_aid;
  logic                  obi_gnt;
  logic                  obi_gntpar;

  // OBI response channel (bridge -> initiator)
  logic                  obi_rvalid;
  logic                  obi_rvalidpar;
  logic [OBI_DW-1:0]     obi_rdata;
  logic [OBI_IDW-1:0]    obi_rid;
  logic                  obi_err;
  logic                  obi_rready;

  // APB channel (bridge -> target and back)
  logic [OBI_AW-1:0]     paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [OBI_DW-1:0]     pwdata;
  logic [OBI_DW/8-1:0]   pstrb;
  logic                  pready;
  logic [OBI_DW-1:0]     prdata;
  logic                  pslverr;

  // Bridge side: OBI slave and APB master
  modport slave (
    input  obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready,
    output obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_rid, obi_err,
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  // Environment side: OBI initiator and APB target
  modport master (
    output obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready,
    input  obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_rid, obi_err,
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/obi_apb_bridge.sv
// rtl/obi_apb_bridge.sv - OBI slave to APB master bridge with one transaction in flight
module obi_apb_bridge #(
  parameter int OBI_AW         = 32,
  parameter int OBI_DW         = 32,
  parameter int OBI_IDW        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  obi_apb_bridge_if.slave bus
);

  localparam int BEW = OBI_DW / 8;
  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit when disabled
  localparam int TCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TC_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [OBI_AW-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [OBI_DW-1:0]   pwdata_q, pwdata_d;
  logic [BEW-1:0]      pstrb_q, pstrb_d;
  logic [OBI_IDW-1:0]  rid_q, rid_d;
  logic [OBI_DW-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [TCW-1:0]      tcnt_q, tcnt_d;

  logic grant;
  logic timeout_hit;
  logic in_resp;

  // Grant is purely combinational in IDLE and suppressed while reset is held
  assign grant       = (state_q == IDLE) && bus.obi_req && !reset;
  // The final stalled ACCESS cycle: counter has already seen TIMEOUT_CYCLES-1 stalls
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !bus.pready && (tcnt_q == TC_LAST);
  assign in_resp     = (state_q == RESP);

  // State and captured-field registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Next-state logic: pready wins over timeout in the same ACCESS cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (grant) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: if (bus.pready || timeout_hit) state_d = RESP;
      RESP:   if (bus.obi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture request on grant, latch response, run the timeout counter
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          paddr_d  = {bus.obi_addr[OBI_AW-1:2], 2'b00};
          pwrite_d = bus.obi_we;
          pwdata_d = bus.obi_we ? bus.obi_wdata : '0;
          pstrb_d  = bus.obi_we ? bus.obi_be : '0;
          rid_d    = bus.obi_aid;
        end
      end
      SETUP: begin
        tcnt_d = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = bus.pslverr;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

  // Outputs: APB strobes from state, response fields zeroed unless rvalid
  always_comb begin
    bus.obi_gnt       = grant;
    bus.obi_gntpar    = ~grant;
    bus.psel          = (state_q == SETUP) || (state_q == ACCESS);
    bus.penable       = (state_q == ACCESS);
    bus.paddr         = paddr_q;
    bus.pwrite        = pwrite_q;
    bus.pwdata        = pwdata_q;
    bus.pstrb         = pstrb_q;
    bus.obi_rvalid    = in_resp;
    bus.obi_rvalidpar = ~in_resp;
    bus.obi_rdata     = in_resp ? rdata_q : '0;
    bus.obi_err       = in_resp ? err_q : 1'b0;
    bus.obi_rid       = in_resp ? rid_q : '0;
  end

endmodule

// File: tb/tb_obi_apb_bridge.sv
// tb/tb_obi_apb_bridge.sv - randomized self-checking bench for obi_apb_bridge
module tb_obi_apb_bridge;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDW  = 1;
  localparam int TB_T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   checking = 1'b0;

  obi_apb_bridge_if #(.OBI_AW(AW), .OBI_DW(DW), .OBI_IDW(IDW)) bus ();

  obi_apb_bridge #(
    .OBI_AW(AW), .OBI_DW(DW), .OBI_IDW(IDW), .TIMEOUT_CYCLES(TB_T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction plan: grant cycle, ACCESS length, last busy cycle, expected fields
  bit          p_active = 1'b0;
  int          p_g, p_A, p_end;
  logic [31:0] p_paddr, p_pwdata, p_rdata;
  logic        p_pwrite, p_err;
  logic [3:0]  p_pstrb;
  logic [0:0]  p_rid;

  // Observations per transaction for literal pinning
  int          obs_lat;
  logic [31:0] obs_rdata, obs_paddr, obs_pwdata;
  logic        obs_err, obs_pwrite;
  logic [3:0]  obs_pstrb;
  logic [0:0]  obs_rid;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  int ck_k;
  bit ck_in, e_gnt, e_psel, e_pen, e_rv;

  always @(negedge clk) begin
    if (checking) begin
      ck_k   = cyc - p_g;
      ck_in  = p_active && (ck_k >= 1) && (cyc <= p_end);
      e_gnt  = !ck_in && bus.obi_req && !reset;
      e_psel = ck_in && (ck_k < 2 + p_A);
      e_pen  = e_psel && (ck_k >= 2);
      e_rv   = ck_in && (ck_k >= 2 + p_A);
      chk("gnt", bus.obi_gnt, e_gnt);
      chk("gntpar", bus.obi_gntpar, !e_gnt);
      chk("psel", bus.psel, e_psel);
      chk("penable", bus.penable, e_pen);
      chk("rvalid", bus.obi_rvalid, e_rv);
      chk("rvalidpar", bus.obi_rvalidpar, !e_rv);
      if (e_psel) begin
        chk("paddr", bus.paddr, p_paddr);
        chk("pwrite", bus.pwrite, p_pwrite);
        chk("pwdata", bus.pwdata, p_pwdata);
        chk("pstrb", bus.pstrb, p_pstrb);
      end
      if (e_rv) begin
        chk("rdata", bus.obi_rdata, p_rdata);
        chk("err", bus.obi_err, p_err);
        chk("rid", bus.obi_rid, p_rid);
      end else begin
        chk("rdata_idle", bus.obi_rdata, 0);
        chk("err_idle", bus.obi_err, 0);
        chk("rid_idle", bus.obi_rid, 0);
      end
      if (p_active && ck_k == 0) obs_lat = -1;
      if (ck_in && ck_k == 1) begin
        obs_paddr  = bus.paddr;
        obs_pwdata = bus.pwdata;
        obs_pstrb  = bus.pstrb;
        obs_pwrite = bus.pwrite;
      end
      if (bus.obi_rvalid && p_active && obs_lat < 0 && ck_k > 0) begin
        obs_lat   = ck_k;
        obs_rdata = bus.obi_rdata;
        obs_err   = bus.obi_err;
        obs_rid   = bus.obi_rid;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic aid, input int w,
                        input logic slverr, input logic [31:0] rd, input int d, input bit hold);
    bit to;
    int a;
    next_cycle();
    to = (TB_T != 0) && (w >= TB_T);
    a  = to ? TB_T : w + 1;
    p_g      = cyc;
    p_A      = a;
    p_end    = cyc + 2 + a + d;
    p_paddr  = {addr[31:2], 2'b00};
    p_pwrite = we;
    p_pwdata = we ? wdata : 32'h0;
    p_pstrb  = we ? be : 4'h0;
    p_rdata  = to ? 32'h0 : (we ? 32'h0 : rd);
    p_err    = to ? 1'b1 : slverr;
    p_rid    = aid;
    p_active = 1'b1;
    bus.obi_req    = 1'b1;
    bus.obi_addr   = addr;
    bus.obi_we     = we;
    bus.obi_be     = be;
    bus.obi_wdata  = wdata;
    bus.obi_aid    = aid;
    bus.pready     = 1'b0;
    bus.prdata     = $urandom;
    bus.pslverr    = 1'b0;
    bus.obi_rready = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 2 + a + d; k++) begin
      next_cycle();
      bus.obi_req = hold;
      if (hold) begin
        bus.obi_addr  = $urandom;
        bus.obi_we    = 1'($urandom_range(0, 1));
        bus.obi_wdata = $urandom;
      end
      bus.pready  = (k == 2 + w);
      bus.prdata  = (k == 2 + w) ? rd : $urandom;
      bus.pslverr = (k == 2 + w) ? slverr : 1'($urandom_range(0, 1));
      if (k >= 2 + a) bus.obi_rready = (k == 2 + a + d);
      else            bus.obi_rready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      bus.obi_req    = 1'b0;
      bus.pready     = 1'($urandom_range(0, 1));
      bus.prdata     = $urandom;
      bus.pslverr    = 1'($urandom_range(0, 1));
      bus.obi_rready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit hold;
    bus.obi_req = 1'b1; bus.obi_addr = 32'h0; bus.obi_we = 1'b0; bus.obi_be = 4'h0;
    bus.obi_wdata = 32'h0; bus.obi_aid = 1'b0; bus.obi_rready = 1'b0;
    bus.pready = 1'b0; bus.prdata = 32'h0; bus.pslverr = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    chk("reset_gnt", bus.obi_gnt, 0);
    chk("reset_gntpar", bus.obi_gntpar, 1);
    chk("reset_rvalidpar", bus.obi_rvalidpar, 1);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);
    chk("reset_pstrb", bus.pstrb, 0);
    chk("reset_pwrite", bus.pwrite, 0);
    reset = 1'b0;
    bus.obi_req = 1'b0;

    // Read, zero wait states
    do_txn(32'h1000_0006, 1'b0, 4'hF, 32'hAAAA_5555, 1'b1, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    settle();
    chk("rd0_lat", obs_lat, 3);
    chk("rd0_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("rd0_rid", obs_rid, 1);
    chk("rd0_err", obs_err, 0);
    chk("rd0_paddr", obs_paddr, 32'h1000_0004);
    chk("rd0_pstrb", obs_pstrb, 0);
    idle_cycles(1);

    // Write, three wait states (pready on the final permitted ACCESS cycle)
    do_txn(32'h2000_0010, 1'b1, 4'h3, 32'h1234_5678, 1'b0, 3, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    settle();
    chk("wr3_lat", obs_lat, 6);
    chk("wr3_rdata", obs_rdata, 0);
    chk("wr3_err", obs_err, 0);
    chk("wr3_pwdata", obs_pwdata, 32'h1234_5678);
    chk("wr3_pstrb", obs_pstrb, 4'h3);
    chk("wr3_pwrite", obs_pwrite, 1);

    // Slave error on a read
    do_txn(32'h3000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 1, 1'b1, 32'hFFFF_FFFF, 1, 1'b0);
    settle();
    chk("slverr_err", obs_err, 1);
    chk("slverr_rdata", obs_rdata, 32'hFFFF_FFFF);
    chk("slverr_lat", obs_lat, 4);

    // Timeout: pready never arrives within the window
    do_txn(32'h4000_0008, 1'b0, 4'h0, 32'h0, 1'b1, 20, 1'b0, 32'h5A5A_5A5A, 0, 1'b0);
    settle();
    chk("tmo_lat", obs_lat, 6);
    chk("tmo_err", obs_err, 1);
    chk("tmo_rdata", obs_rdata, 0);

    // Backpressure with request held, followed by an immediate grant
    do_txn(32'h5000_0004, 1'b0, 4'h0, 32'h0, 1'b1, 0, 1'b0, 32'h0BAD_F00D, 5, 1'b1);
    do_txn(32'h6000_0000, 1'b1, 4'hC, 32'h8765_4321, 1'b0, 0, 1'b0, 32'h0, 0, 1'b0);
    settle();
    chk("bp_next_lat", obs_lat, 3);
    chk("bp_next_pstrb", obs_pstrb, 4'hC);

    // Reset during ACCESS aborts the transaction
    next_cycle();
    p_g = cyc; p_A = TB_T; p_end = cyc + 2;
    p_paddr = 32'h7000_0000; p_pwrite = 1'b1; p_pwdata = 32'h1111_2222; p_pstrb = 4'hF;
    p_rdata = 32'h0; p_err = 1'b0; p_rid = 1'b1; p_active = 1'b1;
    bus.obi_req = 1'b1; bus.obi_addr = 32'h7000_0001; bus.obi_we = 1'b1; bus.obi_be = 4'hF;
    bus.obi_wdata = 32'h1111_2222; bus.obi_aid = 1'b1; bus.pready = 1'b0; bus.obi_rready = 1'b0;
    next_cycle();
    bus.obi_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    settle();
    chk("abort_psel", bus.psel, 0);
    chk("abort_penable", bus.penable, 0);
    chk("abort_rvalid", bus.obi_rvalid, 0);
    chk("abort_paddr", bus.paddr, 0);
    chk("abort_pwdata", bus.pwdata, 0);
    idle_cycles(3);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      do_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 3), hold);
      if (!hold) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
